// File: rtl/tw_slave_regfile.sv
// tw_slave_regfile: responder end of the 3-wire serial link.
// Decodes R/W + address + data frames from the 3w master and serves a small
// local register file. All link inputs are resynchronised to in_clk and edges
// are detected on the synchronised copies.
// Optional build macro: TW_SLAVE_ID_REG_EN (address 0 becomes a read-only ID).
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no frame in progress, bus released
// ST_CMD     | cs seen low, waiting for the R/W bit
// ST_ADDR    | shifting in ADDR_BITS address bits
// ST_WDATA   | shifting in DATA_BITS write data bits
// ST_RDATA   | shifting out DATA_BITS read data bits, bus driven
// ST_WAIT_CS | frame complete, ignoring tw edges until cs rises
module tw_slave_regfile #(
    parameter int ADDR_BITS     = 10,
    parameter int DATA_BITS     = 32,
    parameter int REG_ADDR_BITS = 4,
    parameter int SYNC_STAGES   = 2   // must be >= 2
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_tw_clock,
    input  logic                 in_tw_cs,
    inout  wire                  io_tw_data,
    output logic                 out_wr_strobe,
    output logic [ADDR_BITS-1:0] out_wr_addr,
    output logic [DATA_BITS-1:0] out_wr_data,
    output logic                 out_busy,
    output logic                 out_frame_err
);

    localparam int NREGS = 2 ** REG_ADDR_BITS;
    localparam int MAXB  = (ADDR_BITS > DATA_BITS) ? ADDR_BITS : DATA_BITS;
    localparam int CW    = $clog2(MAXB + 1);
    localparam int FW    = $clog2(SYNC_STAGES + 2);

`ifdef TW_SLAVE_ID_REG_EN
    localparam logic [DATA_BITS-1:0] ID_VAL = DATA_BITS'(32'hC0DE_3001);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_WAIT_CS
    } state_t;

    state_t                   state;
    logic [SYNC_STAGES-1:0]   clk_sync;
    logic [SYNC_STAGES-1:0]   cs_sync;
    logic [SYNC_STAGES-1:0]   dat_sync;
    logic                     clk_prev;
    logic                     cs_prev;
    logic [FW-1:0]            flush_cnt;
    logic                     armed;
    logic [CW-1:0]            bit_cnt;
    logic                     rw;
    logic [ADDR_BITS-1:0]     addr_q;
    logic [DATA_BITS-1:0]     shreg;
    logic                     drive_en;
    logic                     drive_bit;
    logic                     wr_pend;
    logic [DATA_BITS-1:0]     regs [NREGS];

    logic                     clk_s;
    logic                     cs_s;
    logic                     dat_s;
    logic                     tw_rise;
    logic                     tw_fall;
    logic                     cs_rise;
    logic                     cs_fall;
    logic [ADDR_BITS-1:0]     addr_next;
    logic [REG_ADDR_BITS-1:0] rd_idx;
    logic                     rd_in_range;
    logic [DATA_BITS-1:0]     rd_value;
    logic [REG_ADDR_BITS-1:0] wr_idx;
    logic                     wr_in_range;
    logic                     wr_reg_ok;

    assign io_tw_data = drive_en ? drive_bit : 1'bz;

    assign clk_s   = clk_sync[SYNC_STAGES-1];
    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign dat_s   = dat_sync[SYNC_STAGES-1];
    assign tw_rise = clk_s & ~clk_prev;
    assign tw_fall = ~clk_s & clk_prev;
    assign cs_rise = cs_s & ~cs_prev;
    // A cs fall only counts once cs has been seen genuinely high since reset,
    // so a reset in the middle of a frame does not restart decoding halfway.
    assign cs_fall = armed & cs_prev & ~cs_s;

    assign addr_next   = {addr_q[ADDR_BITS-2:0], dat_s};
    assign rd_idx      = addr_next[REG_ADDR_BITS-1:0];
    assign rd_in_range = ((addr_next >> REG_ADDR_BITS) == '0);
    assign wr_idx      = addr_q[REG_ADDR_BITS-1:0];
    assign wr_in_range = ((addr_q >> REG_ADDR_BITS) == '0);

`ifdef TW_SLAVE_ID_REG_EN
    assign wr_reg_ok = wr_in_range && (wr_idx != '0);
`else
    assign wr_reg_ok = wr_in_range;
`endif

    // Read value presented when the address phase completes
    always_comb begin
        rd_value = '0;
        if (rd_in_range) begin
            rd_value = regs[rd_idx];
        end
`ifdef TW_SLAVE_ID_REG_EN
        if (rd_in_range && (rd_idx == '0)) begin
            rd_value = ID_VAL;
        end
`endif
    end

    // Input synchronisers, previous-sample registers and post-reset arming
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            clk_sync  <= '0;
            cs_sync   <= '1;
            dat_sync  <= '0;
            clk_prev  <= 1'b0;
            cs_prev   <= 1'b1;
            flush_cnt <= FW'(SYNC_STAGES + 1);
            armed     <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], in_tw_clock};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], in_tw_cs};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], io_tw_data};
            clk_prev <= clk_s;
            cs_prev  <= cs_s;
            if (flush_cnt != '0) begin
                flush_cnt <= flush_cnt - 1'b1;
            end else if (cs_s && cs_prev) begin
                armed <= 1'b1;
            end
        end
    end

    // Frame decoder, bus driver, write commit and register file
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            rw            <= 1'b0;
            addr_q        <= '0;
            shreg         <= '0;
            drive_en      <= 1'b0;
            drive_bit     <= 1'b0;
            wr_pend       <= 1'b0;
            out_wr_strobe <= 1'b0;
            out_wr_addr   <= '0;
            out_wr_data   <= '0;
            out_busy      <= 1'b0;
            out_frame_err <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            out_wr_strobe <= 1'b0;
            out_frame_err <= 1'b0;
            wr_pend       <= 1'b0;

            // Commit one cycle after the last write-data bit was captured
            if (wr_pend) begin
                out_wr_strobe <= 1'b1;
                out_wr_addr   <= addr_q;
                out_wr_data   <= shreg;
                if (wr_reg_ok) begin
                    regs[wr_idx] <= shreg;
                end
            end

            if (state == ST_IDLE) begin
                drive_en <= 1'b0;
                if (cs_fall) begin
                    state    <= ST_CMD;
                    out_busy <= 1'b1;
                end
            end else if (cs_rise) begin
                state    <= ST_IDLE;
                out_busy <= 1'b0;
                drive_en <= 1'b0;
                if (state != ST_WAIT_CS) begin
                    out_frame_err <= 1'b1;
                end
            end else begin
                case (state)
                    ST_CMD: begin
                        if (tw_rise) begin
                            rw      <= dat_s;
                            bit_cnt <= CW'(ADDR_BITS);
                            state   <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        if (tw_rise) begin
                            addr_q  <= addr_next;
                            bit_cnt <= bit_cnt - 1'b1;
                            if (bit_cnt == CW'(1)) begin
                                bit_cnt <= CW'(DATA_BITS);
                                if (rw) begin
                                    state <= ST_WDATA;
                                end else begin
                                    state <= ST_RDATA;
                                    shreg <= rd_value;
                                end
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (tw_rise) begin
                            shreg   <= {shreg[DATA_BITS-2:0], dat_s};
                            bit_cnt <= bit_cnt - 1'b1;
                            if (bit_cnt == CW'(1)) begin
                                state   <= ST_WAIT_CS;
                                wr_pend <= 1'b1;
                            end
                        end
                    end
                    ST_RDATA: begin
                        // Master samples on its rising edge; we update after its falling edge
                        if (tw_fall) begin
                            drive_en  <= 1'b1;
                            drive_bit <= shreg[DATA_BITS-1];
                            shreg     <= {shreg[DATA_BITS-2:0], 1'b0};
                        end
                        if (tw_rise) begin
                            bit_cnt <= bit_cnt - 1'b1;
                            if (bit_cnt == CW'(1)) begin
                                state    <= ST_WAIT_CS;
                                drive_en <= 1'b0;
                            end
                        end
                    end
                    ST_WAIT_CS: begin
                        drive_en <= 1'b0;
                    end
                    default: begin
                        state    <= ST_IDLE;
                        drive_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tw_slave_regfile.sv
// tb_tw_slave_regfile: directed bench acting as the 3w master for tw_slave_regfile.
// The data line has a pull-up, so a released bus reads as 1.
module tb_tw_slave_regfile;

    localparam int H = 6;   // in_clk cycles per tw half period

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        tw_clk;
    logic        tw_cs;
    logic        m_oe;
    logic        m_dat;
    wire         tw_data;
    logic        out_wr_strobe;
    logic [9:0]  out_wr_addr;
    logic [31:0] out_wr_data;
    logic        out_busy;
    logic        out_frame_err;

    int n_pass  = 0;
    int n_total = 0;
    int strobe_cnt = 0;
    int err_cnt    = 0;

    logic [31:0] rd;

    pullup (tw_data);
    assign tw_data = m_oe ? m_dat : 1'bz;

    always #5 in_clk = ~in_clk;

    tw_slave_regfile #(
        .ADDR_BITS    (10),
        .DATA_BITS    (32),
        .REG_ADDR_BITS(4),
        .SYNC_STAGES  (2)
    ) dut (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .in_tw_clock  (tw_clk),
        .in_tw_cs     (tw_cs),
        .io_tw_data   (tw_data),
        .out_wr_strobe(out_wr_strobe),
        .out_wr_addr  (out_wr_addr),
        .out_wr_data  (out_wr_data),
        .out_busy     (out_busy),
        .out_frame_err(out_frame_err)
    );

    always @(negedge in_clk) begin
        if (out_wr_strobe) strobe_cnt++;
        if (out_frame_err) err_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_c(input int n);
        repeat (n) @(negedge in_clk);
    endtask

    task automatic tw_bit_out(input logic b);
        m_oe  = 1'b1;
        m_dat = b;
        wait_c(H);
        tw_clk = 1'b1;
        wait_c(H);
        tw_clk = 1'b0;
    endtask

    task automatic tw_bit_in(output logic b);
        m_oe = 1'b0;
        wait_c(H);
        tw_clk = 1'b1;
        b = tw_data;
        wait_c(H);
        tw_clk = 1'b0;
    endtask

    task automatic frame(input logic rw, input logic [9:0] a, input logic [31:0] wd,
                         input int nd, output logic [31:0] rdo);
        logic b;
        rdo   = '0;
        tw_cs = 1'b0;
        m_oe  = 1'b1;
        m_dat = 1'b0;
        wait_c(H);
        tw_bit_out(rw);
        chk("busy_mid_frame", {31'd0, out_busy}, 32'd1);
        for (int i = 9; i >= 0; i--) tw_bit_out(a[i]);
        if (rw) begin
            for (int i = 31; i > 31 - nd; i--) tw_bit_out(wd[i]);
        end else begin
            m_oe = 1'b0;
            @(negedge in_clk);
            chk("bus_released_before_data", {31'd0, tw_data}, 32'd1);
            for (int i = 0; i < nd; i++) begin
                tw_bit_in(b);
                rdo = {rdo[30:0], b};
            end
            @(negedge in_clk);
            chk("bus_released_after_data", {31'd0, tw_data}, 32'd1);
        end
        m_oe = 1'b0;
        wait_c(H);
        tw_cs = 1'b1;
        wait_c(3 * H);
    endtask

    initial begin
        logic b;
        in_rst = 1'b1;
        tw_clk = 1'b0;
        tw_cs  = 1'b1;
        m_oe   = 1'b0;
        m_dat  = 1'b0;
        wait_c(4);
        chk("rst_strobe", {31'd0, out_wr_strobe}, 32'd0);
        chk("rst_frame_err", {31'd0, out_frame_err}, 32'd0);
        chk("rst_busy", {31'd0, out_busy}, 32'd0);
        chk("rst_wr_addr", {22'd0, out_wr_addr}, 32'd0);
        chk("rst_wr_data", out_wr_data, 32'd0);
        chk("rst_bus_released", {31'd0, tw_data}, 32'd1);
        in_rst = 1'b0;
        wait_c(2 * H);

        // Write 0x005 <- DEADBEEF
        frame(1'b1, 10'h005, 32'hDEAD_BEEF, 32, rd);
        chk("wr5_strobe_cnt", strobe_cnt, 1);
        chk("wr5_addr", {22'd0, out_wr_addr}, 32'h005);
        chk("wr5_data", out_wr_data, 32'hDEAD_BEEF);
        chk("wr5_busy_end", {31'd0, out_busy}, 32'd0);
        chk("wr5_no_err", err_cnt, 0);

        // Read 0x005
        frame(1'b0, 10'h005, 32'd0, 32, rd);
        chk("rd5_data", rd, 32'hDEAD_BEEF);
        chk("rd5_no_strobe", strobe_cnt, 1);

        // Out-of-range read, write, read-back; alias index 0xF must stay clear
        frame(1'b0, 10'h3FF, 32'd0, 32, rd);
        chk("rd3ff_data", rd, 32'd0);
        frame(1'b1, 10'h3FF, 32'hCAFE_F00D, 32, rd);
        chk("wr3ff_strobe_cnt", strobe_cnt, 2);
        chk("wr3ff_addr", {22'd0, out_wr_addr}, 32'h3FF);
        chk("wr3ff_data", out_wr_data, 32'hCAFE_F00D);
        frame(1'b0, 10'h3FF, 32'd0, 32, rd);
        chk("rd3ff_after_wr", rd, 32'd0);
        frame(1'b0, 10'h00F, 32'd0, 32, rd);
        chk("rd00f_untouched", rd, 32'd0);

        // Short write frame to 0x002: aborted
        frame(1'b1, 10'h002, 32'h1234_5678, 20, rd);
        chk("abort_err_cnt", err_cnt, 1);
        chk("abort_no_strobe", strobe_cnt, 2);
        chk("abort_wr_addr_kept", {22'd0, out_wr_addr}, 32'h3FF);
        chk("abort_busy_end", {31'd0, out_busy}, 32'd0);
        frame(1'b0, 10'h002, 32'd0, 32, rd);
        chk("rd002_after_abort", rd, 32'd0);

        // Address 0 and top in-range address 0x00F
        frame(1'b1, 10'h000, 32'h0000_0001, 32, rd);
        chk("wr000_strobe_cnt", strobe_cnt, 3);
        chk("wr000_addr", {22'd0, out_wr_addr}, 32'h000);
        chk("wr000_data", out_wr_data, 32'h0000_0001);
        frame(1'b0, 10'h000, 32'd0, 32, rd);
`ifdef TW_SLAVE_ID_REG_EN
        chk("rd000_id", rd, 32'hC0DE_3001);
`else
        chk("rd000_data", rd, 32'h0000_0001);
`endif
        frame(1'b1, 10'h00F, 32'h0F0F_0F0F, 32, rd);
        chk("wr00f_strobe_cnt", strobe_cnt, 4);
        frame(1'b0, 10'h00F, 32'd0, 32, rd);
        chk("rd00f_data", rd, 32'h0F0F_0F0F);

        // Reset during read data bit 10 of an out-of-range read (slave drives 0)
        tw_cs = 1'b0;
        m_oe  = 1'b1;
        m_dat = 1'b0;
        wait_c(H);
        tw_bit_out(1'b0);
        for (int i = 9; i >= 0; i--) tw_bit_out(1'b1);
        m_oe = 1'b0;
        for (int i = 0; i < 10; i++) tw_bit_in(b);
        wait_c(H - 1);
        chk("rdata_bit10_driven", {31'd0, tw_data}, 32'd0);
        in_rst = 1'b1;
        @(negedge in_clk);
        chk("rst_mid_bus_released", {31'd0, tw_data}, 32'd1);
        @(negedge in_clk);
        chk("rst_mid_busy", {31'd0, out_busy}, 32'd0);
        chk("rst_mid_wr_addr", {22'd0, out_wr_addr}, 32'd0);
        chk("rst_mid_wr_data", out_wr_data, 32'd0);
        in_rst = 1'b0;
        wait_c(1);
        tw_clk = 1'b1;
        wait_c(H);
        tw_clk = 1'b0;
        rd = '0;
        for (int i = 11; i < 32; i++) begin
            tw_bit_in(b);
            rd = {rd[30:0], b};
        end
        chk("rst_rest_of_frame_released", rd, 32'h001F_FFFF);
        wait_c(H);
        tw_cs = 1'b1;
        wait_c(3 * H);
        chk("rst_frame_no_err", err_cnt, 1);
        chk("rst_frame_no_strobe", strobe_cnt, 4);
        chk("rst_frame_busy", {31'd0, out_busy}, 32'd0);

        // Registers cleared, next frames decode normally
        frame(1'b0, 10'h005, 32'd0, 32, rd);
        chk("rd005_after_rst", rd, 32'd0);
        frame(1'b0, 10'h00F, 32'd0, 32, rd);
        chk("rd00f_after_rst", rd, 32'd0);
        frame(1'b1, 10'h005, 32'h1234_5678, 32, rd);
        chk("wr5b_strobe_cnt", strobe_cnt, 5);
        chk("wr5b_data", out_wr_data, 32'h1234_5678);
        frame(1'b0, 10'h005, 32'd0, 32, rd);
        chk("rd5b_data", rd, 32'h1234_5678);
        chk("final_err_cnt", err_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
